// File: rtl/parking_controller.sv
// parking_controller
//   Six-slot parking lot controller. A free-running timer timestamps each
//   check-in. A button press on a free slot checks it in. A press on an
//   occupied slot checks it out and shows the fee until the display
//   acknowledges it.
//
// Parameters
//   RATE     fee units charged per elapsed timer count
//   FEE_MIN  minimum fee charged on any check-out
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous active-high reset
//   tick        one-cycle timebase pulse, advances timer
//   btn         synchronised, debounced button level
//   selector    slot number, valid 1..6
//   ack         display acknowledge, releases a shown fee
//   timer       free-running parking time count
//   occupied    bit k-1 high = slot k occupied
//   free_count  number of free slots
//   full        all six slots occupied
//   fee         last computed fee
//   fee_valid   fee is being shown, held until ack
//   busy        FSM not in IDLE
//   err         one-cycle pulse on an invalid selector
module parking_controller #(
  parameter int unsigned RATE    = 1,
  parameter int unsigned FEE_MIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        btn,
  input  logic [3:0]  selector,
  input  logic        ack,
  output logic [10:0] timer,
  output logic [5:0]  occupied,
  output logic [2:0]  free_count,
  output logic        full,
  output logic [10:0] fee,
  output logic        fee_valid,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE,
    DECODE,
    CHECKIN,
    CHECKOUT,
    SHOWFEE
  } state_t;

  state_t state, next_state;

  logic        btn_q;
  logic        armed;
  logic        press;
  logic [3:0]  sel_snap;
  logic [10:0] time_snap;
  logic [10:0] slot_time [6];

  logic        sel_valid;
  logic [2:0]  slot_idx;
  logic [10:0] elapsed;
  logic [42:0] product;
  logic [10:0] fee_sat;
  logic [10:0] fee_next;
  logic [2:0]  free_cnt;

  // armed stays low for the first cycle after reset. A button that is
  // already high when reset releases is then copied into btn_q before any
  // edge can be seen, so it never counts as a press.
  assign press = armed & btn & ~btn_q;

  assign sel_valid = (sel_snap != 4'd0) && (sel_snap <= 4'd6);
  assign slot_idx  = 3'(sel_snap - 4'd1);
  assign busy      = (state != IDLE);

  // Fee path. The subtraction wraps modulo 2048 along with the timer. The
  // product is kept wide so that saturation is exact for any RATE.
  always_comb begin
    elapsed = time_snap - slot_time[slot_idx];
    product = 43'(elapsed) * 43'(RATE);
    if (product > 43'd2047) begin
      fee_sat = 11'h7FF;
    end else begin
      fee_sat = product[10:0];
    end
    if (fee_sat < 11'(FEE_MIN)) begin
      fee_next = 11'(FEE_MIN);
    end else begin
      fee_next = fee_sat;
    end
  end

  // Occupancy summaries
  always_comb begin
    free_cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      if (!occupied[i]) begin
        free_cnt = free_cnt + 3'd1;
      end
    end
  end

  assign free_count = free_cnt;
  assign full       = &occupied;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (press) begin
          next_state = DECODE;
        end
      end
      DECODE: begin
        if (!sel_valid) begin
          next_state = IDLE;
        end else if (occupied[slot_idx]) begin
          next_state = CHECKOUT;
        end else begin
          next_state = CHECKIN;
        end
      end
      CHECKIN:  next_state = IDLE;
      CHECKOUT: next_state = SHOWFEE;
      SHOWFEE: begin
        if (ack) begin
          next_state = IDLE;
        end
      end
      default:  next_state = IDLE;
    endcase
  end

  // Datapath. Slot and fee registers change only in the state that owns
  // them. A reset at any point therefore leaves no half-finished update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer     <= '0;
      btn_q     <= 1'b0;
      armed     <= 1'b0;
      sel_snap  <= '0;
      time_snap <= '0;
      occupied  <= '0;
      fee       <= '0;
      fee_valid <= 1'b0;
      err       <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        slot_time[i] <= '0;
      end
    end else begin
      btn_q <= btn;
      armed <= 1'b1;
      err   <= 1'b0;
      if (tick) begin
        timer <= timer + 11'd1;
      end
      case (state)
        IDLE: begin
          // Uses the timer value from before this edge's tick.
          if (press) begin
            sel_snap  <= selector;
            time_snap <= timer;
          end
        end
        DECODE: begin
          if (!sel_valid) begin
            err <= 1'b1;
          end
        end
        CHECKIN: begin
          slot_time[slot_idx] <= time_snap;
          occupied[slot_idx]  <= 1'b1;
        end
        CHECKOUT: begin
          fee                 <= fee_next;
          fee_valid           <= 1'b1;
          occupied[slot_idx]  <= 1'b0;
          slot_time[slot_idx] <= '0;
        end
        SHOWFEE: begin
          if (ack) begin
            fee_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_parking_controller.sv
// tb_parking_controller
//   Directed self-checking bench for parking_controller. The stimulus
//   process pushes each expected event into a scoreboard queue. A
//   separate monitor pops an entry whenever the DUT shows an event
//   (check-in, fee shown, err pulse) and compares it with the DUT.
module tb_parking_controller;

  localparam int K_CHECKIN = 0;
  localparam int K_FEE     = 1;
  localparam int K_ERR     = 2;

  typedef struct {
    int          kind;
    logic [10:0] fee;
    logic [5:0]  occ;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        btn;
  logic [3:0]  selector;
  logic        ack;
  logic [10:0] timer;
  logic [5:0]  occupied;
  logic [2:0]  free_count;
  logic        full;
  logic [10:0] fee;
  logic        fee_valid;
  logic        busy;
  logic        err;

  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   model_timer;
  logic       prev_fv;
  logic [5:0] prev_occ;

  parking_controller #(.RATE(1), .FEE_MIN(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .tick       (tick),
    .btn        (btn),
    .selector   (selector),
    .ack        (ack),
    .timer      (timer),
    .occupied   (occupied),
    .free_count (free_count),
    .full       (full),
    .fee        (fee),
    .fee_valid  (fee_valid),
    .busy       (busy),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic push_expect(input int kind, input logic [10:0] f,
                             input logic [5:0] occ);
    exp_t e;
    e.kind = kind;
    e.fee  = f;
    e.occ  = occ;
    exp_q.push_back(e);
  endtask

  task automatic pop_compare(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checkOutput("unexpected_event", kind, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      checkOutput("event_kind", kind, e.kind);
      checkOutput("event_occupied", 32'(occupied), 32'(e.occ));
      if (kind == K_FEE) begin
        checkOutput("event_fee", 32'(fee), 32'(e.fee));
      end
    end
  endtask

  // Monitor: watches for DUT events on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      prev_fv  = 1'b0;
      prev_occ = '0;
    end else begin
      if (err) pop_compare(K_ERR);
      if (fee_valid && !prev_fv) pop_compare(K_FEE);
      if ((occupied & ~prev_occ) != 6'd0) pop_compare(K_CHECKIN);
      prev_fv  = fee_valid;
      prev_occ = occupied;
    end
  end

  // Pulse tick until the model timer reaches target, then compare timers.
  task automatic advance_to(input int target);
    int n;
    n = (target - model_timer + 2048) % 2048;
    if (n > 0) begin
      tick = 1'b1;
      repeat (n) @(posedge clk);
      #1 tick = 1'b0;
      model_timer = target;
    end
    checkOutput("timer", 32'(timer), target);
  endtask

  // Hold btn high for hold cycles, then leave time for the transaction.
  task automatic applyStimulus(input logic [3:0] sel, input int hold,
                               input logic with_tick);
    btn      = 1'b1;
    selector = sel;
    tick     = with_tick;
    @(posedge clk);
    #1 tick = 1'b0;
    if (with_tick) model_timer = (model_timer + 1) % 2048;
    repeat (hold - 1) begin
      @(posedge clk);
      #1;
    end
    btn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    checkOutput("fee_valid_after_ack", 32'(fee_valid), 0);
    checkOutput("busy_after_ack", 32'(busy), 0);
  endtask

  task automatic wait_drain();
    int cnt;
    cnt = 0;
    while (exp_q.size() != 0 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    checkOutput("scoreboard_drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    model_timer = 0;
    reset       = 1'b1;
    btn         = 1'b1;
    selector    = 4'd3;
    tick        = 1'b0;
    ack         = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_timer", 32'(timer), 0);
    checkOutput("reset_occupied", 32'(occupied), 0);
    checkOutput("reset_free_count", 32'(free_count), 6);
    checkOutput("reset_full", 32'(full), 0);
    checkOutput("reset_fee", 32'(fee), 0);
    checkOutput("reset_fee_valid", 32'(fee_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_err", 32'(err), 0);

    // btn already high when reset releases: no press
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("btn_held_at_reset_busy", 32'(busy), 0);
    checkOutput("btn_held_at_reset_occ", 32'(occupied), 0);
    btn = 1'b0;
    @(posedge clk);
    #1;

    // Check-in slot 3 at timer 10, with latency check
    advance_to(10);
    push_expect(K_CHECKIN, 11'd0, 6'b000100);
    btn      = 1'b1;
    selector = 4'd3;
    @(posedge clk);
    #1 btn = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_edge_n1", 32'(occupied), 0);
    @(posedge clk);
    @(negedge clk);
    checkOutput("latency_edge_n2", 32'(occupied), 32'b000100);
    @(posedge clk);
    #1;
    wait_drain();
    checkOutput("free_count_one_in", 32'(free_count), 5);
    checkOutput("fee_valid_after_checkin", 32'(fee_valid), 0);

    // Check-out slot 3 at timer 25 gives fee 15
    advance_to(25);
    push_expect(K_FEE, 11'd15, 6'b000000);
    applyStimulus(4'd3, 1, 1'b0);
    wait_drain();
    checkOutput("showfee_fee_valid", 32'(fee_valid), 1);
    // A press during SHOWFEE is ignored
    applyStimulus(4'd1, 1, 1'b0);
    checkOutput("showfee_press_busy", 32'(busy), 1);
    checkOutput("showfee_press_fee", 32'(fee), 15);
    checkOutput("showfee_press_occ", 32'(occupied), 0);
    do_ack();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_queued_press", 32'(occupied), 0);

    // ack outside SHOWFEE does nothing
    ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    checkOutput("idle_ack_fee_valid", 32'(fee_valid), 0);
    checkOutput("idle_ack_busy", 32'(busy), 0);

    // Invalid selectors
    push_expect(K_ERR, 11'd0, 6'b000000);
    applyStimulus(4'd0, 1, 1'b0);
    checkOutput("err_sel0_busy", 32'(busy), 0);
    checkOutput("err_sel0_err_low", 32'(err), 0);
    push_expect(K_ERR, 11'd0, 6'b000000);
    applyStimulus(4'd9, 1, 1'b0);
    wait_drain();
    checkOutput("err_sel9_occ", 32'(occupied), 0);
    checkOutput("err_sel9_busy", 32'(busy), 0);

    // Wrap: check-in at 2040, check-out at 5 gives fee 13
    advance_to(2040);
    push_expect(K_CHECKIN, 11'd0, 6'b000001);
    applyStimulus(4'd1, 1, 1'b0);
    advance_to(5);
    push_expect(K_FEE, 11'd13, 6'b000000);
    applyStimulus(4'd1, 1, 1'b0);
    wait_drain();
    do_ack();

    // Same timer value: FEE_MIN, then the slot is reusable at once
    push_expect(K_CHECKIN, 11'd0, 6'b001000);
    applyStimulus(4'd4, 1, 1'b0);
    push_expect(K_FEE, 11'd1, 6'b000000);
    applyStimulus(4'd4, 1, 1'b0);
    wait_drain();
    do_ack();
    push_expect(K_CHECKIN, 11'd0, 6'b001000);
    applyStimulus(4'd4, 1, 1'b0);

    // Tick and press together: snapshot takes 5, timer moves to 6
    push_expect(K_CHECKIN, 11'd0, 6'b001010);
    applyStimulus(4'd2, 1, 1'b1);
    checkOutput("tick_press_timer", 32'(timer), 6);

    // Fill the lot
    push_expect(K_CHECKIN, 11'd0, 6'b001011);
    applyStimulus(4'd1, 1, 1'b0);
    push_expect(K_CHECKIN, 11'd0, 6'b001111);
    applyStimulus(4'd3, 1, 1'b0);
    checkOutput("free_count_two", 32'(free_count), 2);
    push_expect(K_CHECKIN, 11'd0, 6'b011111);
    applyStimulus(4'd5, 1, 1'b0);
    push_expect(K_CHECKIN, 11'd0, 6'b111111);
    applyStimulus(4'd6, 1, 1'b0);
    wait_drain();
    checkOutput("full_flag", 32'(full), 1);
    checkOutput("full_free_count", 32'(free_count), 0);

    // Slot 2 was stamped 5; check-out at 20 gives 15
    advance_to(20);
    push_expect(K_FEE, 11'd15, 6'b111101);
    applyStimulus(4'd2, 1, 1'b0);
    wait_drain();
    do_ack();

    // btn held for 20 cycles gives a single check-in
    push_expect(K_CHECKIN, 11'd0, 6'b111111);
    applyStimulus(4'd2, 20, 1'b0);
    wait_drain();
    checkOutput("held_btn_full", 32'(full), 1);
    checkOutput("held_btn_busy", 32'(busy), 0);

    // Reset during SHOWFEE with fee 15 (slot 2 stamped 20, out at 35)
    advance_to(35);
    push_expect(K_FEE, 11'd15, 6'b111101);
    applyStimulus(4'd2, 1, 1'b0);
    wait_drain();
    checkOutput("pre_reset_fee_valid", 32'(fee_valid), 1);
    #2 reset = 1'b1;
    #1;
    checkOutput("async_reset_fee", 32'(fee), 0);
    checkOutput("async_reset_fee_valid", 32'(fee_valid), 0);
    checkOutput("async_reset_occ", 32'(occupied), 0);
    checkOutput("async_reset_timer", 32'(timer), 0);
    checkOutput("async_reset_busy", 32'(busy), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    model_timer = 0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_reset_occ", 32'(occupied), 0);
    checkOutput("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/parking_controller.md
PARKING_CONTROLLER -- requirements
Module: parking_controller

Interface
REQ-001 Parameter RATE, default 1: fee units charged per elapsed timer count.
REQ-002 Parameter FEE_MIN, default 1: minimum fee charged on any check-out.
REQ-003 clk  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-cycle timebase pulse that advances the parking timer.
REQ-006 btn  input  1  synchronised, debounced user button (level).
REQ-007 selector  input  4  slot number; valid values are 1..6.
REQ-008 ack  input  1  display acknowledge; releases a shown fee.
REQ-009 timer  output  11  free-running parking time count.
REQ-010 occupied  output  6  bit k-1 high = slot k occupied.
REQ-011 free_count  output  3  number of clear bits in occupied (0..6).
REQ-012 full  output  1  high when all six slots are occupied.
REQ-013 fee  output  11  last computed fee, valid while fee_valid is high.
REQ-014 fee_valid  output  1  high from fee computation until ack.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.
REQ-016 err  output  1  one-cycle pulse on an invalid selector.

Function
REQ-017 timer SHALL increment by 1 on each cycle with tick high and SHALL wrap 2047 -> 0.
REQ-018 The block SHALL hold six 11-bit check-in time registers, one per slot, internal only.
REQ-019 A press SHALL be a btn rising edge, detected against a registered copy of btn.
REQ-020 FSM states SHALL be IDLE, DECODE, CHECKIN, CHECKOUT, SHOWFEE.
REQ-021 IDLE: on a press, the FSM SHALL latch selector and the current timer value into snapshot registers and go to DECODE.
REQ-022 If tick and a press occur in the same cycle, the snapshot SHALL take the pre-increment timer value.
REQ-023 DECODE: if selector is 0 or 7..15, err SHALL pulse for one cycle and the FSM SHALL return to IDLE with no other state change.
REQ-024 DECODE: if the selected slot is free, go to CHECKIN; if occupied, go to CHECKOUT.
REQ-025 CHECKIN SHALL store the snapshot time into the slot register, set its occupied bit, and return to IDLE.
REQ-026 CHECKOUT SHALL compute elapsed = (snapshot - checkin time) mod 2048.
REQ-027 CHECKOUT SHALL set fee = elapsed*RATE, saturated at 2047, raised to FEE_MIN if smaller.
REQ-028 CHECKOUT SHALL also clear the occupied bit and the slot register to 0, then go to SHOWFEE.
REQ-029 SHOWFEE SHALL hold fee_valid high and fee stable until a cycle with ack high, then return to IDLE.
REQ-030 fee_valid SHALL go low on the cycle after ack is sampled.
REQ-031 Presses arriving in any state other than IDLE SHALL be ignored and not queued.
REQ-032 A btn held high SHALL produce only one press.
REQ-033 Latency: for a press sampled at edge N, the occupied update and fee_valid SHALL be visible after edge N+2.
REQ-034 free_count and full SHALL be combinational functions of occupied.
REQ-035 ack outside SHOWFEE SHALL have no effect.
REQ-036 After a check-out completes, the slot SHALL be immediately reusable by the next press.

Reset
REQ-037 On reset high, the block SHALL immediately set: FSM IDLE, timer 0, occupied 0, all slot registers 0, fee 0, fee_valid 0, err 0, and the btn edge register 0.
REQ-038 Reset asserted mid-operation, including SHOWFEE, SHALL abort the transaction with no partial slot update surviving.
REQ-039 A btn already high when reset deasserts SHALL NOT count as a press.

Verification
REQ-040 Reset; press with selector=3 at timer=10 -> occupied=000100, free_count=5, fee_valid=0.
REQ-041 Slot 3 occupied since 10; press at timer=25 -> fee=15, fee_valid high until ack, occupied=000000.
REQ-042 Slot 1 checked in at 2040; timer wraps; check-out at 5 -> fee=13. Check-in and check-out in the same timer value -> fee=FEE_MIN=1.
REQ-043 Press with selector=0, then selector=9 -> err one-cycle pulse each, occupied unchanged, busy back low after 2 cycles.
REQ-044 Fill slots 1..6 -> full=1, free_count=0. Press during SHOWFEE -> ignored. btn held 20 cycles -> single transaction.
REQ-045 Reset asserted during SHOWFEE with fee=15 -> fee=0, fee_valid=0, occupied=0, timer=0 asynchronously.
